dffe_pipe_init: RTL and testbench
=================================

# dffe_pipe_init

Parametrised multi-stage pipeline register with per-stage valid tracking, a configurable reset/flush value, stall, flush and optional bubble collapsing. It generalises the single-bit enable flop with preset-to-one into a WIDTH-bit, DEPTH-stage latch bank. Processor pipeline boundaries and the plotter command path use it wherever a stallable, flushable, reset-to-known-value stage is needed.

## Interface
- WIDTH, 32: data bits per stage.
- DEPTH, 2: number of stages; legal range 1..8.
- INIT, {WIDTH{1'b1}}: value loaded into every stage's data on reset and on flush.
- FALL_EDGE, 1: 1 = all state updates on negedge clk; 0 = posedge clk.
- COLLAPSE, 0: 1 = invalid stages absorb upstream data even while stalled; 0 = strict lockstep shift.
- clk  in  1  single clock. Only the edge selected by FALL_EDGE is used.
- clr  in  1  reset, synchronous, active-high, sampled on the active edge.
- en  in  1  downstream advance. The last stage hands off and the pipe shifts.
- flush  in  1  invalidate all stages. Synchronous.
- in_valid  in  1  d carries a valid item.
- d  in  WIDTH  input data.
- in_ready  out  1  combinational. Stage 0 will load on this edge.
- q  out  WIDTH  data of stage DEPTH-1.
- out_valid  out  1  valid bit of stage DEPTH-1.
- stage_valid  out  DEPTH  valid bit per stage; bit 0 = input stage.
- count  out  4  number of valid stages, 0..DEPTH.

## Operation
- State per stage i: data[i] (WIDTH bits) and valid[i].
- Move chain (combinational):
  - move[DEPTH] = en.
  - COLLAPSE=0: move[i] = en for every i.
  - COLLAPSE=1: move[i] = ~valid[i] | move[i+1].
- in_ready = move[0] & ~flush & ~clr.
- Priority on each active edge is clr > flush > shift.
- clr:
  - data[i] = INIT and valid[i] = 0 for all i.
  - count = 0.
- flush (no clr):
  - same as clr for data and valid.
  - input is dropped even if in_valid = 1.
  - count = 0.
- Shift (no clr, no flush), for each stage i with move[i] = 1:
  - valid[i] <= upstream valid. Upstream is in_valid for i = 0, else valid[i-1].
  - data[i] <= upstream data only when upstream valid = 1; otherwise data[i] holds.
- Stages with move[i] = 0 hold data and valid.
- count:
  - +1 when an item enters (in_valid & in_ready).
  - -1 when an item leaves (out_valid & en).
  - both on the same edge: unchanged.
  - must always equal the popcount of stage_valid.
- In COLLAPSE=1 a stalled pipe (en=0) fills from the front until every stage is valid; in_ready then drops.
- No item is duplicated or lost except by flush/clr.

## Timing
- Reset values:
  - q = INIT, out_valid = 0, stage_valid = 0, count = 0.
  - in_ready = 0 while clr is high.
  - After clr drops, in_ready = en (COLLAPSE=0) or 1 (COLLAPSE=1).
- Latency: with en held high, an item accepted on edge N appears on q/out_valid after edge N+DEPTH-1. That is DEPTH edges from d to q inclusive of the capture edge.
- Throughput: one item per active edge when en = 1.
- FALL_EDGE=1: d, in_valid, en, flush and clr are sampled at negedge. Outputs change only just after negedge.
- clr mid-stream: all in-flight items are discarded on that edge. The next edge may accept new input.
- flush and en together: flush wins. out_valid still reads 1 before the edge, but the item is considered consumed by the sink.
- DEPTH=1: stage 0 is the output stage, so move[0] = en (or ~valid[0] | en).

## Test plan
- Reset: WIDTH=8, INIT=8'hA5, clr high one edge with a full pipe -> q = 8'hA5, out_valid = 0, count = 0; in_ready is 0 during clr.
- Lockstep: COLLAPSE=0, DEPTH=3, en=1, stream 8'h01,02,03 on consecutive edges -> 8'h01 on q after the 3rd edge, then 02 and 03 on following edges; count peaks at 3.
- Stall hold: COLLAPSE=0, insert 8'h11 then en=0 for 4 edges -> stage contents and count frozen, in_ready = 0; en=1 resumes without loss.
- Collapse: COLLAPSE=1, DEPTH=3, en=0, in_valid=1 with 8'h21,22,23,24 -> first three accepted; q = 8'h21 with out_valid after the 3rd edge; in_ready = 0 for 8'h24; count = 3.
- Flush vs. input: pipe holding 2 items, flush=1, in_valid=1, en=1 on the same edge -> all valid cleared, data = INIT, count = 0, new input not accepted.
- Edge mode: FALL_EDGE=1 vs 0 with the same stimulus -> identical sequences, with updates aligned to negedge and posedge respectively.

Source files
------------

// File: rtl/dffe_pipe_init.sv
// dffe_pipe_init: WIDTH-bit, DEPTH-stage stallable/flushable pipeline register
// with per-stage valid bits, a reset/flush value and optional bubble collapsing.
//
// Parameters
//   WIDTH     data bits per stage
//   DEPTH     number of stages, 1..8
//   INIT      data value loaded into every stage on clr and on flush
//   FALL_EDGE 1: state updates on negedge clk, 0: on posedge clk
//   COLLAPSE  1: invalid stages absorb upstream data while stalled
//             0: strict lockstep shift on en
// Ports
//   clk         clock (only the edge selected by FALL_EDGE is used)
//   clr         synchronous active-high reset
//   en          downstream advance; last stage hands off, pipe shifts
//   flush       synchronous invalidate of all stages
//   in_valid    d carries a valid item
//   d           input data
//   in_ready    combinational: stage 0 loads on the coming active edge
//   q           data of the last stage
//   out_valid   valid bit of the last stage
//   stage_valid valid bit per stage, bit 0 = input stage
//   count       number of valid stages
module dffe_pipe_init #(
    parameter int unsigned      WIDTH     = 32,
    parameter int unsigned      DEPTH     = 2,
    parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b1}},
    parameter bit               FALL_EDGE = 1'b1,
    parameter bit               COLLAPSE  = 1'b0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] d,
    output logic             in_ready,
    output logic [WIDTH-1:0] q,
    output logic             out_valid,
    output logic [DEPTH-1:0] stage_valid,
    output logic [3:0]       count
);

    logic [DEPTH-1:0][WIDTH-1:0] data_r;
    logic [DEPTH-1:0][WIDTH-1:0] data_nxt;
    logic [DEPTH-1:0]            valid_r;
    logic [DEPTH-1:0]            valid_nxt;
    logic [3:0]                  count_r;
    logic [3:0]                  count_nxt;
    logic [DEPTH:0]              move;
    logic                        take;
    logic                        leave;

    // Move chain: in collapse mode a stage may load whenever it is empty or
    // its downstream neighbour is moving, so bubbles are squeezed out.
    always_comb begin
        move        = '0;
        move[DEPTH] = en;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (COLLAPSE) begin
                move[i] = ~valid_r[i] | move[i+1];
            end else begin
                move[i] = en;
            end
        end
    end

    assign in_ready = move[0] & ~flush & ~clr;
    assign take     = in_valid & in_ready;
    assign leave    = valid_r[DEPTH-1] & en;

    // Next state: clr and flush both restore INIT and clear valid; otherwise
    // each moving stage takes its upstream valid, and data only when valid.
    always_comb begin
        data_nxt  = data_r;
        valid_nxt = valid_r;
        count_nxt = count_r;
        if (clr || flush) begin
            data_nxt  = {DEPTH{INIT}};
            valid_nxt = '0;
            count_nxt = '0;
        end else begin
            if (move[0]) begin
                valid_nxt[0] = in_valid;
                if (in_valid) begin
                    data_nxt[0] = d;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (move[i]) begin
                    valid_nxt[i] = valid_r[i-1];
                    if (valid_r[i-1]) begin
                        data_nxt[i] = data_r[i-1];
                    end
                end
            end
            count_nxt = count_r + 4'(take) - 4'(leave);
        end
    end

    // State register on the selected clock edge.
    generate
        if (FALL_EDGE) begin : g_negedge
            always_ff @(negedge clk) begin
                data_r  <= data_nxt;
                valid_r <= valid_nxt;
                count_r <= count_nxt;
            end
        end else begin : g_posedge
            always_ff @(posedge clk) begin
                data_r  <= data_nxt;
                valid_r <= valid_nxt;
                count_r <= count_nxt;
            end
        end
    endgenerate

    assign q           = data_r[DEPTH-1];
    assign out_valid   = valid_r[DEPTH-1];
    assign stage_valid = valid_r;
    assign count       = count_r;

endmodule

// File: tb/tb_dffe_pipe_init.sv
// Bench for dffe_pipe_init: three instances (posedge lockstep, posedge
// collapse, negedge lockstep) with per-instance scoreboards.
module tb_dffe_pipe_init;

    localparam int unsigned W    = 8;
    localparam int unsigned D    = 3;
    localparam logic [7:0]  INIT = 8'hA5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clr_i [3];
    logic       en_i  [3];
    logic       fl_i  [3];
    logic       iv_i  [3];
    logic [7:0] d_i   [3];
    logic       ir_o  [3];
    logic       ov_o  [3];
    logic [7:0] q_o   [3];
    logic [2:0] sv_o  [3];
    logic [3:0] cnt_o [3];

    dffe_pipe_init #(.WIDTH(W), .DEPTH(D), .INIT(INIT), .FALL_EDGE(1'b0), .COLLAPSE(1'b0)) u_a (
        .clk(clk), .clr(clr_i[0]), .en(en_i[0]), .flush(fl_i[0]), .in_valid(iv_i[0]), .d(d_i[0]),
        .in_ready(ir_o[0]), .q(q_o[0]), .out_valid(ov_o[0]), .stage_valid(sv_o[0]), .count(cnt_o[0]));
    dffe_pipe_init #(.WIDTH(W), .DEPTH(D), .INIT(INIT), .FALL_EDGE(1'b0), .COLLAPSE(1'b1)) u_b (
        .clk(clk), .clr(clr_i[1]), .en(en_i[1]), .flush(fl_i[1]), .in_valid(iv_i[1]), .d(d_i[1]),
        .in_ready(ir_o[1]), .q(q_o[1]), .out_valid(ov_o[1]), .stage_valid(sv_o[1]), .count(cnt_o[1]));
    dffe_pipe_init #(.WIDTH(W), .DEPTH(D), .INIT(INIT), .FALL_EDGE(1'b1), .COLLAPSE(1'b0)) u_c (
        .clk(clk), .clr(clr_i[2]), .en(en_i[2]), .flush(fl_i[2]), .in_valid(iv_i[2]), .d(d_i[2]),
        .in_ready(ir_o[2]), .q(q_o[2]), .out_valid(ov_o[2]), .stage_valid(sv_o[2]), .count(cnt_o[2]));

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] sb0 [$];
    logic [7:0] sb1 [$];
    logic [7:0] sb2 [$];

    task automatic check(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h want %0h", nm, k, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [7:0] v);
        case (k)
            0:       sb0.push_back(v);
            1:       sb1.push_back(v);
            default: sb2.push_back(v);
        endcase
    endtask

    // Monitor side: an item leaves whenever out_valid and en are both high.
    task automatic sb_pop(input int k);
        logic [7:0] exp_v;
        bit         have;
        have  = 1'b0;
        exp_v = 8'h00;
        case (k)
            0:       if (sb0.size() > 0) begin exp_v = sb0.pop_front(); have = 1'b1; end
            1:       if (sb1.size() > 0) begin exp_v = sb1.pop_front(); have = 1'b1; end
            default: if (sb2.size() > 0) begin exp_v = sb2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            n_cmp++;
            n_fail++;
            $display("FAIL sb_unexpected dut%0d: got %0h want none", k, q_o[k]);
        end else begin
            check("sb_q", k, q_o[k], exp_v);
        end
    endtask

    // Sample half a cycle away from each instance's active edge.
    always @(negedge clk) if (ov_o[0] === 1'b1 && en_i[0] && !clr_i[0]) sb_pop(0);
    always @(negedge clk) if (ov_o[1] === 1'b1 && en_i[1] && !clr_i[1]) sb_pop(1);
    always @(posedge clk) if (ov_o[2] === 1'b1 && en_i[2] && !clr_i[2]) sb_pop(2);

    task automatic cyc(input int k);
        if (k == 2) @(negedge clk);
        else        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input logic c, input logic e, input logic f,
                         input logic v, input logic [7:0] dd);
        clr_i[k] = c;
        en_i[k]  = e;
        fl_i[k]  = f;
        iv_i[k]  = v;
        d_i[k]   = dd;
    endtask

    task automatic run_lock(input int k);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        #1 check("ready_after_clr", k, 8'(ir_o[k]), 8'd1);
        // lockstep stream
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01); push(k, 8'h01);
        if (k == 2) @(posedge clk);
        else        @(negedge clk);
        #1 check("edge_align", k, 8'(sv_o[k]), 8'h00);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02); push(k, 8'h02);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03); push(k, 8'h03);
        cyc(k);
        check("lock_q", k, q_o[k], 8'h01);
        check("lock_ov", k, 8'(ov_o[k]), 8'd1);
        check("lock_cnt_peak", k, 8'(cnt_o[k]), 8'd3);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) cyc(k);
        check("lock_cnt_drain", k, 8'(cnt_o[k]), 8'd0);
        check("lock_ov_drain", k, 8'(ov_o[k]), 8'd0);
        // stall hold
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h11); push(k, 8'h11);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check("stall_ready", k, 8'(ir_o[k]), 8'd0);
        for (int i = 0; i < 4; i++) begin
            cyc(k);
            check("stall_sv", k, 8'(sv_o[k]), 8'h01);
            check("stall_cnt", k, 8'(cnt_o[k]), 8'd1);
        end
        drive(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) cyc(k);
        check("stall_cnt_end", k, 8'(cnt_o[k]), 8'd0);
        // flush beats input and en
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h31);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h32);
        cyc(k);
        check("pre_flush_cnt", k, 8'(cnt_o[k]), 8'd2);
        check("pre_flush_sv", k, 8'(sv_o[k]), 8'h03);
        drive(k, 1'b0, 1'b1, 1'b1, 1'b1, 8'h33);
        #1 check("flush_ready", k, 8'(ir_o[k]), 8'd0);
        cyc(k);
        check("flush_sv", k, 8'(sv_o[k]), 8'h00);
        check("flush_cnt", k, 8'(cnt_o[k]), 8'd0);
        check("flush_q", k, q_o[k], INIT);
        check("flush_ov", k, 8'(ov_o[k]), 8'd0);
        // clr with a full pipe
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h42);
        cyc(k);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b1, 8'h43);
        cyc(k);
        check("full_sv", k, 8'(sv_o[k]), 8'h07);
        drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check("clr_ready", k, 8'(ir_o[k]), 8'd0);
        cyc(k);
        check("clr_q", k, q_o[k], INIT);
        check("clr_ov", k, 8'(ov_o[k]), 8'd0);
        check("clr_cnt", k, 8'(cnt_o[k]), 8'd0);
        check("clr_sv", k, 8'(sv_o[k]), 8'h00);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check("lock_ready_en0", k, 8'(ir_o[k]), 8'd0);
    endtask

    task automatic run_coll(input int k);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        #1 check("coll_ready_idle", k, 8'(ir_o[k]), 8'd1);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h21); push(k, 8'h21);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22); push(k, 8'h22);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h23); push(k, 8'h23);
        cyc(k);
        check("coll_q", k, q_o[k], 8'h21);
        check("coll_ov", k, 8'(ov_o[k]), 8'd1);
        check("coll_cnt", k, 8'(cnt_o[k]), 8'd3);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h24);
        #1 check("coll_full_ready", k, 8'(ir_o[k]), 8'd0);
        cyc(k);
        check("coll_hold_cnt", k, 8'(cnt_o[k]), 8'd3);
        check("coll_hold_sv", k, 8'(sv_o[k]), 8'h07);
        check("coll_hold_q", k, q_o[k], 8'h21);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) cyc(k);
        check("coll_drain_cnt", k, 8'(cnt_o[k]), 8'd0);
        check("coll_drain_ov", k, 8'(ov_o[k]), 8'd0);
        // bubbles close up while stalled
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h51); push(k, 8'h51);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(k);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b1, 8'h52); push(k, 8'h52);
        cyc(k);
        check("bubble_sv", k, 8'(sv_o[k]), 8'h05);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(k);
        check("bubble_sv_squeeze", k, 8'(sv_o[k]), 8'h06);
        check("bubble_cnt", k, 8'(cnt_o[k]), 8'd2);
        check("bubble_q", k, q_o[k], 8'h51);
        drive(k, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        repeat (3) cyc(k);
        check("bubble_drain_cnt", k, 8'(cnt_o[k]), 8'd0);
        drive(k, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) drive(k, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        repeat (2) cyc(0);
        for (int k = 0; k < 3; k++) begin
            check("rst_q", k, q_o[k], INIT);
            check("rst_ov", k, 8'(ov_o[k]), 8'd0);
            check("rst_cnt", k, 8'(cnt_o[k]), 8'd0);
            check("rst_sv", k, 8'(sv_o[k]), 8'h00);
            check("rst_ready", k, 8'(ir_o[k]), 8'd0);
        end
        run_lock(0);
        run_lock(2);
        run_coll(1);
        repeat (4) cyc(0);
        check("sb_left", 0, 8'(sb0.size()), 8'd0);
        check("sb_left", 1, 8'(sb1.size()), 8'd0);
        check("sb_left", 2, 8'(sb2.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
